// File: rtl/demux_pkg.sv
// Shared types and defaults for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int WIDTH_DEFAULT = 3;
  localparam int DEPTH_DEFAULT = 2;

  typedef enum logic {
    DEST_OUT0 = 1'b0,
    DEST_OUT1 = 1'b1
  } dest_t;

  // Occupancy needs one more bit than the pointers so that "full" is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with registered storage, head-of-queue read port and occupancy count.
module demux_fifo
  import demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Guarded locally so the count can never over- or underflow whatever the caller does.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & o_valid;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is reset on purpose so the head reads zero after reset, not stale data.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1_to_2_3_bit_stream.sv
// Steers one valid/ready stream into two independently buffered output streams by a per-beat select.
module demux_1_to_2_3_bit_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CW-1:0]    out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    out1_count
);

  dest_t w_dest;
  logic  w_full0;
  logic  w_full1;
  logic  w_accept;
  logic  w_push0;
  logic  w_push1;

  assign w_dest = dest_t'(in_sel);

  // Ready depends only on the addressed FIFO's fullness; a pop that same cycle does not help.
  assign in_ready = (w_dest == DEST_OUT1) ? ~w_full1 : ~w_full0;

  assign w_accept = in_valid & in_ready;
  assign w_push0  = w_accept & (w_dest == DEST_OUT0);
  assign w_push1  = w_accept & (w_dest == DEST_OUT1);

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push0),
    .i_wr_data (in_data),
    .i_pop     (out0_ready),
    .o_rd_data (out0_data),
    .o_count   (out0_count),
    .o_full    (w_full0),
    .o_valid   (out0_valid)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push1),
    .i_wr_data (in_data),
    .i_pop     (out1_ready),
    .o_rd_data (out1_data),
    .o_count   (out1_count),
    .o_full    (w_full1),
    .o_valid   (out1_valid)
  );

endmodule

// File: tb/tb_demux_1_to_2_3_bit_stream.sv
// Queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_demux_1_to_2_3_bit_stream;

  localparam int WIDTH = 3;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    out0_count;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out1_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one queue per channel holding the payloads the DUT must still deliver.
  int q0[$];
  int q1[$];

  demux_1_to_2_3_bit_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_count (out0_count),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_count (out1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input int d);
    in_valid = v;
    in_sel   = s;
    in_data  = WIDTH'(d);
  endtask

  // Compare process: on each falling edge check outputs against the model, then advance
  // the model by what the coming rising edge must do with the inputs now applied.
  always @(negedge clk) begin
    int  sz0;
    int  sz1;
    bit  acc;
    if (!rst_n) begin
      check("rst out0_valid", 32'(out0_valid), 32'd0);
      check("rst out1_valid", 32'(out1_valid), 32'd0);
      check("rst out0_count", 32'(out0_count), 32'd0);
      check("rst out1_count", 32'(out1_count), 32'd0);
      check("rst out0_data",  32'(out0_data),  32'd0);
      check("rst out1_data",  32'(out1_data),  32'd0);
      check("rst in_ready",   32'(in_ready),   32'd1);
      q0.delete();
      q1.delete();
    end else begin
      sz0 = q0.size();
      sz1 = q1.size();
      check("out0_valid", 32'(out0_valid), 32'(sz0 != 0));
      check("out1_valid", 32'(out1_valid), 32'(sz1 != 0));
      check("out0_count", 32'(out0_count), 32'(sz0));
      check("out1_count", 32'(out1_count), 32'(sz1));
      if (sz0 != 0) check("out0_data", 32'(out0_data), 32'(q0[0]));
      if (sz1 != 0) check("out1_data", 32'(out1_data), 32'(q1[0]));
      check("in_ready", 32'(in_ready), 32'(in_sel ? (sz1 < DEPTH) : (sz0 < DEPTH)));
      acc = in_valid && (in_sel ? (sz1 < DEPTH) : (sz0 < DEPTH));
      if (out0_ready && sz0 != 0) void'(q0.pop_front());
      if (out1_ready && sz1 != 0) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(int'(in_data));
        else        q0.push_back(int'(in_data));
      end
    end
  end

  initial begin
    int got[$];
    int idx;

    rst_n = 1'b1;
    drive(0, 0, 0);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("init out0_valid", 32'(out0_valid), 32'd0);
    check("init out0_count", 32'(out0_count), 32'd0);
    check("init out1_count", 32'(out1_count), 32'd0);
    check("init out0_data",  32'(out0_data),  32'd0);
    check("init in_ready",   32'(in_ready),   32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Steering: 4 to out1, then 0 to out0, consumers ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1, 1, 4);
    step();
    check("steer out1_valid", 32'(out1_valid), 32'd1);
    check("steer out1_data",  32'(out1_data),  32'd4);
    check("steer out0_valid early", 32'(out0_valid), 32'd0);
    drive(1, 0, 0);
    step();
    check("steer out0_valid", 32'(out0_valid), 32'd1);
    check("steer out0_data",  32'(out0_data),  32'd0);
    check("steer out1 drained", 32'(out1_valid), 32'd0);
    drive(0, 0, 0);
    step();
    check("steer out0 drained", 32'(out0_count), 32'd0);

    // Backpressure isolation.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1, 0, 5);
    step();
    drive(1, 0, 6);
    step();
    check("bp out0_count", 32'(out0_count), 32'd2);
    check("bp in_ready sel0", 32'(in_ready), 32'd0);
    drive(1, 1, 7);
    #1;
    check("bp in_ready sel1", 32'(in_ready), 32'd1);
    step();
    check("bp out1_data",  32'(out1_data),  32'd7);
    check("bp out1_count", 32'(out1_count), 32'd1);
    check("bp out0_count held", 32'(out0_count), 32'd2);

    // Full plus pop: no pass-through while full.
    drive(1, 0, 3);
    out0_ready = 1'b1;
    #1;
    check("full+pop in_ready", 32'(in_ready), 32'd0);
    step();
    check("full+pop out0_count", 32'(out0_count), 32'd1);
    check("full+pop in_ready after", 32'(in_ready), 32'd1);
    check("full+pop out0_data", 32'(out0_data), 32'd6);

    // Simultaneous push and pop at count 1.
    step();
    check("pushpop out0_count", 32'(out0_count), 32'd1);
    check("pushpop out0_data",  32'(out0_data),  32'd3);

    drive(0, 0, 0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) step();
    check("drain out0_count", 32'(out0_count), 32'd0);
    check("drain out1_count", 32'(out1_count), 32'd0);

    // Ordering and pointer wrap: 0..7 into out0 under a random consumer.
    idx = 0;
    for (int c = 0; c < 300; c++) begin
      drive(idx < 8, 0, idx);
      out0_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out0_valid && out0_ready) got.push_back(int'(out0_data));
      @(posedge clk);
      #1;
      if (idx >= 8 && got.size() >= 8) break;
    end
    drive(0, 0, 0);
    check("order count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check("order value", 32'(got[i]), 32'(i));
    end

    // Random traffic with mixed backpressure.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      out0_ready = (c % 64 < 32) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      out1_ready = (c % 48 < 24) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      step();
    end

    // Asynchronous reset mid-stream with out0 holding two entries.
    drive(0, 0, 0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) step();
    out0_ready = 1'b0;
    drive(1, 0, 5);
    step();
    drive(1, 0, 2);
    step();
    check("pre-reset out0_count", 32'(out0_count), 32'd2);
    #2;
    drive(0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async rst out0_valid", 32'(out0_valid), 32'd0);
    check("async rst out0_data",  32'(out0_data),  32'd0);
    check("async rst out0_count", 32'(out0_count), 32'd0);
    check("async rst in_ready",   32'(in_ready),   32'd1);
    step();
    step();
    rst_n = 1'b1;
    out1_ready = 1'b0;
    drive(1, 1, 5);
    step();
    check("post-reset out1_valid", 32'(out1_valid), 32'd1);
    check("post-reset out1_data",  32'(out1_data),  32'd5);
    drive(0, 0, 0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
